// File: rtl/ram_controller_pkg.sv
// Shared types and sizing for the RAM request/response front end.
package ram_controller_pkg;

    localparam int unsigned RAM_ADDR_WIDTH = 5;
    localparam int unsigned RAM_DATA_WIDTH = 32;
    localparam int unsigned RAM_DEPTH      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

endpackage : ram_controller_pkg

// File: rtl/ram_controller.sv
// Front end owning the single RAM port: valid/ready reads and writes plus a bulk fill.
module ram_controller
    import ram_controller_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int unsigned DEPTH      = RAM_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_data,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,

    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_value,
    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_input_data,
    output logic                  ram_write_enabled,
    input  logic [DATA_WIDTH-1:0] ram_output_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   fill_count;
    logic [DATA_WIDTH-1:0]   fill_value;
    logic [DATA_WIDTH-1:0]   resp_data_q;

    assign resp_data = resp_data_q;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fill counter and captured fill word; counter wraps naturally after the last address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_count <= '0;
            fill_value <= '0;
        end else if (state == IDLE && clear_start) begin
            fill_count <= '0;
            fill_value <= clear_value;
        end else if (state == CLEAR) begin
            fill_count <= fill_count + ADDR_WIDTH'(1);
        end
    end

    // Read data capture: RAM output is valid during READ, held through RESP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_data_q <= '0;
        end else if (state == READ) begin
            resp_data_q <= ram_output_data;
        end
    end

    // Next state and RAM/handshake drive; everything forced quiet while reset is held.
    always_comb begin
        next_state        = state;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        busy              = (state != IDLE);
        ram_address       = '0;
        ram_input_data    = '0;
        ram_write_enabled = 1'b0;

        unique case (state)
            IDLE: begin
                req_ready = !clear_start;
                if (clear_start) begin
                    next_state = CLEAR;
                end else if (req_valid) begin
                    ram_address = req_address;
                    if (req_write) begin
                        ram_input_data    = req_data;
                        ram_write_enabled = 1'b1;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            CLEAR: begin
                ram_address       = fill_count;
                ram_input_data    = fill_value;
                ram_write_enabled = 1'b1;
                if (fill_count == LAST_ADDR) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (!reset_n) begin
            req_ready         = 1'b0;
            resp_valid        = 1'b0;
            busy              = 1'b0;
            ram_address       = '0;
            ram_input_data    = '0;
            ram_write_enabled = 1'b0;
        end
    end

endmodule : ram_controller

// File: doc/ram_controller.md
# ram_controller

Request/response front end that owns the single port of the 32x32 synchronous data RAM and drives its `clock`/`address`/`input_data`/`write_enabled` inputs, consuming `output_data`. It converts valid/ready read and write requests from the datapath into correctly timed RAM cycles and absorbs the RAM's one-cycle read latency. It also runs a bulk fill sequence that writes one value to every word. It sits between the CPU memory stage and the RAM instance in the `computer` top level.

## Interface
- `ADDR_WIDTH`, 5, RAM address width.
- `DATA_WIDTH`, 32, RAM word width.
- `DEPTH`, 32, number of words; always 2**ADDR_WIDTH.

- Clocking: one clock; reset is asynchronous and active-low.
- `clock` in 1: system clock, shared with the RAM.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid` and `req_ready` are both high on a rising edge.
- `req_write` in 1: 1 = write, 0 = read.
- `req_address` in ADDR_WIDTH: word address.
- `req_data` in DATA_WIDTH: write data.
- `resp_valid` out 1: read data available.
- `resp_ready` in 1: consumer takes the response.
- `resp_data` out DATA_WIDTH: read data, registered.
- `clear_start` in 1: request a fill; sampled in IDLE only.
- `clear_value` in DATA_WIDTH: fill word, captured when `clear_start` is accepted.
- `busy` out 1: high in any state other than IDLE.
- `ram_address` out ADDR_WIDTH: to RAM `address`.
- `ram_input_data` out DATA_WIDTH: to RAM `input_data`.
- `ram_write_enabled` out 1: to RAM `write_enabled`.
- `ram_output_data` in DATA_WIDTH: from RAM `output_data`.

## Operation
- **States:** IDLE, READ, RESP, CLEAR.
- **IDLE:**
  - `req_ready` = !`clear_start`, so a fill has priority over a simultaneous request.
  - Accepted write: `ram_address`/`ram_input_data` = request fields and `ram_write_enabled` = 1, combinationally in the same cycle. The RAM commits at that edge. State stays IDLE. No response is produced. Throughput is one write per cycle.
  - Accepted read: `ram_address` = `req_address` in the same cycle, then go to READ.
  - `clear_start` high: capture `clear_value`, reset the fill counter to 0, go to CLEAR.
  - No request: `ram_address` = 0, `ram_write_enabled` = 0, `ram_input_data` = 0.
- **READ:**
  - `ram_output_data` is valid this cycle. Register it into `resp_data` at the edge and go to RESP.
  - `ram_write_enabled` = 0, `req_ready` = 0.
- **RESP:**
  - `resp_valid` = 1. `resp_data` is held stable until `resp_valid` and `resp_ready` are both high on an edge, then go to IDLE.
  - `req_ready` = 0 throughout.
- **CLEAR:**
  - Each cycle: `ram_address` = counter, `ram_input_data` = captured value, `ram_write_enabled` = 1.
  - The counter increments each cycle. After the write at address DEPTH-1 the counter wraps to 0 and the state returns to IDLE. The fill takes exactly DEPTH cycles.
  - `req_ready` = 0. `clear_start` is ignored.
- **Arithmetic:** the counter is ADDR_WIDTH bits wide with natural wrap. No other arithmetic.
- **Reset (any state, including mid-CLEAR or mid-RESP):**
  - State goes to IDLE. Counter, `resp_data` and the captured value go to 0.
  - While `reset_n` is low: `req_ready`, `resp_valid`, `busy`, `ram_write_enabled` = 0 and `ram_address` = 0.
  - RAM contents are not restored; a partial fill remains.

## Timing
- Write: accepted at edge N, data in the RAM at edge N. A read accepted at edge N+1 returns the new data.
- Read: accepted at edge N, RAM samples the address at N, `resp_data` is loaded at N+1, `resp_valid` is high from N+1.
- Minimum spacing between read acceptances: 3 cycles when `resp_ready` is held high.
- Fill: `busy` is high for DEPTH cycles after the accepting edge. `req_ready` rises in the cycle after the last fill write.
- Outputs are never driven from `resp_ready` combinationally, so there is no path from `resp_ready` to `req_ready` within a cycle.

## Structure
- Package `ram_controller_pkg`:
  - state enum (`IDLE`, `READ`, `RESP`, `CLEAR`);
  - `RAM_ADDR_WIDTH` = 5, `RAM_DATA_WIDTH` = 32;
  - `RAM_DEPTH` = 32.
- Single flat module with no sub-module. The fill counter and FSM are small enough to share one always block per concern. The RAM itself is instantiated by the parent, not inside this block.

## Test plan
- Hold `reset_n` low with `req_valid` = 1 → `req_ready`, `resp_valid`, `busy`, `ram_write_enabled` all 0. After release with `clear_start` = 0 → `req_ready` = 1.
- Write 0xDEADBEEF to address 5, then read address 5 on the next cycle → `resp_valid` rises 1 edge after acceptance with `resp_data` = 0xDEADBEEF.
- Writes to addresses 0–3 with data 0x10–0x13 on 4 consecutive cycles → `ram_write_enabled` high for 4 cycles, `req_ready` never drops. Subsequent reads return 0x10–0x13.
- Read address 5 with `resp_ready` held low for 3 cycles → `resp_valid` and `resp_data` stay stable and `req_ready` = 0. After the handshake, the next read is accepted the cycle after.
- `clear_start` = 1 with `clear_value` = 0xA5A5A5A5 while `req_valid` = 1 → request not accepted; `busy` high for 32 cycles with `ram_address` 0..31. The pending request is then accepted, and reading address 31 returns 0xA5A5A5A5.
- Preload all words with 0x1, start a fill of 0x0, and assert `reset_n` low when the counter = 10 → `ram_write_enabled` and `busy` drop immediately. Words 0–9 read 0x0 and words 10–31 read 0x1.
